// File: rtl/dose_scheduler.sv
// Multi-channel dose reminder: shared tick prescaler, per-channel interval countdown,
// alarm with grace window and saturating miss counters. Define DOSE_SNOOZE_EN for the snooze input.
module dose_scheduler #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 12,
  parameter int TICK_DIV = 1000,
  parameter int GRACE    = 30,
  parameter int MISS_W   = 4
`ifdef DOSE_SNOOZE_EN
  , parameter int SNOOZE_T = 5
`endif
) (
  input  logic                                       clock,
  input  logic                                       rst,
  input  logic [N_CH-1:0]                            enable,
  input  logic [N_CH-1:0]                            ack,
`ifdef DOSE_SNOOZE_EN
  input  logic [N_CH-1:0]                            snooze,
`endif
  input  logic                                       cfg_we,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                           cfg_interval,
  output logic [N_CH-1:0]                            alarm,
  output logic                                       alarm_any,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] active_ch,
  output logic [N_CH*MISS_W-1:0]                     missed_cnt,
  output logic                                       tick
);

  // state   | meaning
  // S_IDLE  | disabled or no interval stored
  // S_COUNT | counting remaining ticks to the next dose
  // S_ALARM | dose due, grace ticks running until ack or miss
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_ALARM = 2'd2;

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PS_W = $clog2(TICK_DIV);
  localparam int GR_W = $clog2(GRACE + 1);

  logic [PS_W-1:0]   pre_cnt;
  logic              tick_int;
  logic [1:0]        st       [N_CH];
  logic [1:0]        st_n     [N_CH];
  logic [CNT_W-1:0]  rem      [N_CH];
  logic [CNT_W-1:0]  rem_n    [N_CH];
  logic [GR_W-1:0]   gr       [N_CH];
  logic [GR_W-1:0]   gr_n     [N_CH];
  logic [MISS_W-1:0] miss     [N_CH];
  logic [MISS_W-1:0] miss_n   [N_CH];
  logic [CNT_W-1:0]  interval [N_CH];
  logic [N_CH-1:0]   reload;
  logic [N_CH-1:0]   alarm_n;
  logic [CH_W-1:0]   active_n;

  assign tick_int = (pre_cnt == PS_W'(TICK_DIV - 1));
  assign tick     = tick_int & ~rst;

  always_comb begin
    alarm_n  = '0;
    active_n = '0;
    reload   = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      st_n[ch]   = st[ch];
      rem_n[ch]  = rem[ch];
      gr_n[ch]   = gr[ch];
      miss_n[ch] = miss[ch];
      if (!enable[ch]) begin
        st_n[ch]  = S_IDLE;
        rem_n[ch] = '0;
        gr_n[ch]  = '0;
      end else begin
        case (st[ch])
          S_IDLE: reload[ch] = 1'b1;
          S_COUNT: begin
            if (tick_int) begin
              if (rem[ch] <= CNT_W'(1)) begin
                st_n[ch] = S_ALARM;
                gr_n[ch] = GR_W'(GRACE);
              end else begin
                rem_n[ch] = rem[ch] - 1'b1;
              end
            end
          end
          S_ALARM: begin
            if (ack[ch]) begin
              reload[ch] = 1'b1;
`ifdef DOSE_SNOOZE_EN
            end else if (snooze[ch]) begin
              st_n[ch]  = S_COUNT;
              rem_n[ch] = CNT_W'(SNOOZE_T);
`endif
            end else if (tick_int) begin
              if (gr[ch] <= GR_W'(1)) begin
                reload[ch] = 1'b1;
                if (miss[ch] != {MISS_W{1'b1}}) miss_n[ch] = miss[ch] + 1'b1;
              end else begin
                gr_n[ch] = gr[ch] - 1'b1;
              end
            end
          end
          default: st_n[ch] = S_IDLE;
        endcase
      end
      // A reload always reads the register as it stood before this edge's write.
      if (reload[ch]) begin
        if (interval[ch] == '0) begin
          st_n[ch] = S_IDLE;
        end else begin
          st_n[ch]  = S_COUNT;
          rem_n[ch] = interval[ch];
        end
      end
      alarm_n[ch] = (st_n[ch] == S_ALARM);
    end
    for (int ch = N_CH - 1; ch >= 0; ch--) begin
      if (alarm_n[ch]) active_n = CH_W'(ch);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      pre_cnt   <= '0;
      alarm     <= '0;
      alarm_any <= 1'b0;
      active_ch <= '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        st[ch]       <= S_IDLE;
        rem[ch]      <= '0;
        gr[ch]       <= '0;
        miss[ch]     <= '0;
        interval[ch] <= '0;
      end
    end else begin
      pre_cnt   <= tick_int ? '0 : pre_cnt + 1'b1;
      alarm     <= alarm_n;
      alarm_any <= |alarm_n;
      active_ch <= active_n;
      for (int ch = 0; ch < N_CH; ch++) begin
        st[ch]   <= st_n[ch];
        rem[ch]  <= rem_n[ch];
        gr[ch]   <= gr_n[ch];
        miss[ch] <= miss_n[ch];
      end
      if (cfg_we && (32'(cfg_ch) < N_CH)) interval[cfg_ch] <= cfg_interval;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_miss
    assign missed_cnt[g*MISS_W +: MISS_W] = miss[g];
  end

endmodule

// File: tb/tb_dose_scheduler.sv
// Directed bench for dose_scheduler at N_CH=2, TICK_DIV=4, CNT_W=4, GRACE=2, MISS_W=2.
// The snooze scenario runs only when DOSE_SNOOZE_EN is defined.
module tb_dose_scheduler;
  localparam int N_CH = 2, CNT_W = 4, TICK_DIV = 4, GRACE = 2, MISS_W = 2;

  logic             clock = 1'b0;
  logic             rst;
  logic [1:0]       enable, ack;
`ifdef DOSE_SNOOZE_EN
  logic [1:0]       snooze;
`endif
  logic             cfg_we;
  logic             cfg_ch;
  logic [CNT_W-1:0] cfg_interval;
  logic [1:0]       alarm;
  logic             alarm_any;
  logic             active_ch;
  logic [3:0]       missed_cnt;
  logic             tick;

  int checks = 0, failures = 0;

  always #5 clock = ~clock;

  dose_scheduler #(
    .N_CH(N_CH), .CNT_W(CNT_W), .TICK_DIV(TICK_DIV), .GRACE(GRACE), .MISS_W(MISS_W)
`ifdef DOSE_SNOOZE_EN
    , .SNOOZE_T(5)
`endif
  ) dut (
    .clock(clock), .rst(rst), .enable(enable), .ack(ack),
`ifdef DOSE_SNOOZE_EN
    .snooze(snooze),
`endif
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_interval(cfg_interval),
    .alarm(alarm), .alarm_any(alarm_any), .active_ch(active_ch),
    .missed_cnt(missed_cnt), .tick(tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Counts ticks consumed until alarm[ch] rises.
  task automatic wait_alarm(input int ch, output int ticks);
    int n = 0;
    ticks = 0;
    while (alarm[ch] !== 1'b1 && n < 64) begin
      if (tick) ticks++;
      step();
      n++;
    end
    check_eq("alarm_rise", 32'(alarm[ch]), 1);
  endtask

  // Counts ticks consumed until alarm[ch] falls on its own.
  task automatic wait_clear(input int ch, output int ticks);
    int n = 0;
    ticks = 0;
    while (alarm[ch] !== 1'b0 && n < 64) begin
      if (tick) ticks++;
      step();
      n++;
    end
    check_eq("alarm_fall", 32'(alarm[ch]), 0);
  endtask

  initial begin
    int t, n, seen;
    logic any_seen;
    rst = 1'b1; enable = '0; ack = '0;
    cfg_we = 1'b0; cfg_ch = 1'b0; cfg_interval = '0;
`ifdef DOSE_SNOOZE_EN
    snooze = '0;
`endif
    repeat (3) step();
    check_eq("rst_alarm", 32'(alarm), 0);
    check_eq("rst_alarm_any", 32'(alarm_any), 0);
    check_eq("rst_active_ch", 32'(active_ch), 0);
    check_eq("rst_tick", 32'(tick), 0);
    check_eq("rst_missed", 32'(missed_cnt), 0);

    // ch0 interval 3: alarm after exactly 3 ticks, ack restarts a full countdown
    rst = 1'b0;
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_interval = 4'd3; enable = 2'b01;
    step();
    cfg_we = 1'b0;
    wait_alarm(0, t);
    check_eq("first_alarm_ticks", t, 3);
    check_eq("first_active_ch", 32'(active_ch), 0);
    check_eq("first_alarm_any", 32'(alarm_any), 1);
    ack = 2'b01; step(); ack = '0;
    check_eq("ack_drop", 32'(alarm), 0);
    check_eq("ack_drop_any", 32'(alarm_any), 0);
    wait_alarm(0, t);
    check_eq("restart_ticks", t, 3);

    // unacknowledged alarm lasts GRACE ticks and counts one miss
    wait_clear(0, t);
    check_eq("grace_ticks", t, 2);
    check_eq("miss_1", 32'(missed_cnt[1:0]), 1);
    wait_alarm(0, t);
    check_eq("reload_after_miss", t, 3);

    // ack coinciding with the final grace tick wins
    n = 0; seen = 0;
    while (n < 32) begin
      if (tick) begin
        seen++;
        if (seen == 2) break;
      end
      step();
      n++;
    end
    check_eq("final_grace_tick_found", seen, 2);
    check_eq("alarm_held_in_grace", 32'(alarm[0]), 1);
    ack = 2'b01; step(); ack = '0;
    check_eq("ack_at_expiry_alarm", 32'(alarm[0]), 0);
    check_eq("ack_at_expiry_miss", 32'(missed_cnt[1:0]), 1);
    wait_alarm(0, t);
    check_eq("ack_at_expiry_reload", t, 3);

    // three further misses: 2, 3, then saturated at 3
    wait_clear(0, t);
    check_eq("miss_2", 32'(missed_cnt[1:0]), 2);
    wait_alarm(0, t);
    wait_clear(0, t);
    check_eq("miss_3", 32'(missed_cnt[1:0]), 3);
    wait_alarm(0, t);
    wait_clear(0, t);
    check_eq("miss_saturate", 32'(missed_cnt[1:0]), 3);

    // disable mid-alarm clears the alarm but keeps the miss count
    wait_alarm(0, t);
    enable = 2'b00; cfg_we = 1'b1; cfg_ch = 1'b1; cfg_interval = 4'd3;
    step();
    cfg_we = 1'b0;
    check_eq("disable_clears", 32'(alarm), 0);
    check_eq("disable_keeps_miss", 32'(missed_cnt[1:0]), 3);

    // both channels alarming together, priority on the lowest index
    enable = 2'b11;
    wait_alarm(0, t);
    check_eq("dual_alarm", 32'(alarm), 3);
    check_eq("dual_active_ch", 32'(active_ch), 0);
    ack = 2'b01; cfg_we = 1'b1; cfg_ch = 1'b0; cfg_interval = 4'd1;
    step();
    ack = '0; cfg_we = 1'b0;
    check_eq("after_ack0_alarm", 32'(alarm), 2);
    check_eq("after_ack0_active", 32'(active_ch), 1);
    check_eq("after_ack0_any", 32'(alarm_any), 1);
    ack = 2'b10; step(); ack = '0;
    check_eq("after_ack1_alarm", 32'(alarm), 0);
    check_eq("after_ack1_active", 32'(active_ch), 0);
    check_eq("after_ack1_any", 32'(alarm_any), 0);
    wait_alarm(0, t);
    check_eq("old_interval_on_reload", t, 3);
    ack = 2'b01; step(); ack = '0;
    wait_alarm(0, t);
    check_eq("new_interval_on_reload", t, 1);

    // reset mid-alarm, then nothing happens until an interval is written
    rst = 1'b1; step();
    check_eq("rst_mid_alarm", 32'(alarm), 0);
    check_eq("rst_mid_any", 32'(alarm_any), 0);
    check_eq("rst_mid_active", 32'(active_ch), 0);
    check_eq("rst_mid_tick", 32'(tick), 0);
    check_eq("rst_mid_missed", 32'(missed_cnt), 0);
    rst = 1'b0;
    any_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      any_seen |= alarm_any;
    end
    check_eq("idle_without_interval", 32'(any_seen), 0);

    // ack during COUNT must not restart the countdown
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_interval = 4'd2;
    step();
    cfg_we = 1'b0;
    step();
    n = 0;
    while (!tick && n < 16) begin
      step();
      n++;
    end
    check_eq("count_tick_found", 32'(tick), 1);
    step();
    ack = 2'b01; step(); ack = '0;
    wait_alarm(0, t);
    check_eq("ack_in_count_ignored", t, 1);

`ifdef DOSE_SNOOZE_EN
    snooze = 2'b01; step(); snooze = '0;
    check_eq("snooze_drop", 32'(alarm[0]), 0);
    wait_alarm(0, t);
    check_eq("snooze_ticks", t, 5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
